// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared definitions for the fetch stage: default bus widths, the HLT
//   opcode, and the fetch FSM state encoding.
//   Items:
//     ADDR_W_DEF / DATA_W_DEF - default address and instruction widths
//     OPC_HLT                 - opcode in instr[15:12] that stops fetching
//     fetch_state_e           - ISSUE / WAIT / HALTED (2-bit)
//     is_hlt_opcode()         - true when a 4-bit opcode is HLT
package cpu_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  localparam logic [3:0] OPC_HLT = 4'hF;

  typedef enum logic [1:0] {
    FETCH_ISSUE  = 2'd0,
    FETCH_WAIT   = 2'd1,
    FETCH_HALTED = 2'd2
  } fetch_state_e;

  function automatic logic is_hlt_opcode(input logic [3:0] opcode);
    return (opcode == OPC_HLT);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if
//   Instruction-memory read bus between the fetch unit and memory.
//   Only one request is ever outstanding; the response may come any number
//   of cycles (at least one) after the request.
//   Signals:
//     mem_req    - one-cycle read request pulse (fetch -> memory)
//     mem_addr   - read address, valid while mem_req=1 (fetch -> memory)
//     mem_rvalid - read data valid (memory -> fetch)
//     mem_rdata  - read data word (memory -> fetch)
//   Modports: master = fetch unit side, slave = memory side.
interface instr_fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rvalid,
    output mem_rdata
  );

endinterface

// File: rtl/fetch_watchdog.sv
// fetch_watchdog
//   Cycle counter guarding one outstanding memory read. It is cleared when
//   the request is issued and counts every cycle spent waiting. expired is
//   raised in the waiting cycle whose increment brings the count to
//   TIMEOUT-1, so the owner leaves the wait state TIMEOUT cycles after the
//   request cycle.
//   Ports:
//     clk, rst_n - clock, asynchronous active-low reset
//     clear      - zero the counter (request cycle)
//     enable     - count this cycle (waiting cycle)
//     expired    - combinational: wait budget used up this cycle
module fetch_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 2);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Compared against TIMEOUT-2 so the flag fires while the counter is about
  // to step onto TIMEOUT-1; the counter itself never wraps because the owner
  // stops enabling it once it has expired.
  assign expired = enable && (count_q == LAST_WAIT);

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage directly downstream of the PC updater. Issues one read per
//   instruction to a variable-latency instruction memory, captures the word
//   for decode, and holds the PC (pc_stall) until each fetch completes.
//   Handles branch flush, HLT detection, misaligned PC and memory timeout.
//   Ports:
//     clk, rst_n  - clock, asynchronous active-low reset
//     pc_in       - current PC from the PC updater
//     flush       - taken-branch redirect; discards the in-flight fetch
//     pc_stall    - to PC updater: hold PC when high (combinational)
//     mem         - memory read bus (master modport)
//     instr       - captured instruction
//     instr_pc    - address instr was fetched from
//     instr_valid - one-cycle pulse when instr/instr_pc are new
//     halted      - sticky: HLT fetched or fetch error
//     fetch_err   - sticky: misaligned PC or memory timeout
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    pc_in,
  input  logic                 flush,
  output logic                 pc_stall,
  instr_fetch_unit_if.master   mem,
  output logic [DATA_W-1:0]    instr,
  output logic [ADDR_W-1:0]    instr_pc,
  output logic                 instr_valid,
  output logic                 halted,
  output logic                 fetch_err
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic              halted_q, halted_d;
  logic              fetch_err_q, fetch_err_d;
  logic              drop_q, drop_d;

  logic              wd_clear;
  logic              wd_enable;
  logic              wd_expired;
  logic              rdata_is_hlt;

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  assign rdata_is_hlt = is_hlt_opcode(mem.mem_rdata[DATA_W-1 -: 4]);

  // Next-state and outputs. pc_stall releases the PC exactly once per
  // accepted non-HLT word, and also on any flush outside HALTED so the PC
  // updater can load the branch target.
  always_comb begin
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = 1'b0;
    halted_d      = halted_q;
    fetch_err_d   = fetch_err_q;
    drop_d        = drop_q;
    mem.mem_req   = 1'b0;
    mem.mem_addr  = pc_in;
    pc_stall      = 1'b1;
    wd_clear      = 1'b0;
    wd_enable     = 1'b0;

    unique case (state_q)
      FETCH_ISSUE: begin
        if (flush) begin
          drop_d   = 1'b1;
          pc_stall = 1'b0;
        end
        if (pc_in[0]) begin
          fetch_err_d = 1'b1;
          halted_d    = 1'b1;
          state_d     = FETCH_HALTED;
        end else begin
          mem.mem_req = 1'b1;
          req_addr_d  = pc_in;
          wd_clear    = 1'b1;
          state_d     = FETCH_WAIT;
        end
      end

      FETCH_WAIT: begin
        wd_enable = 1'b1;
        if (flush) begin
          pc_stall = 1'b0;
        end
        if (mem.mem_rvalid) begin
          // A response already marked stale, or one that collides with a
          // flush, belongs to the old path and is thrown away.
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = FETCH_ISSUE;
          end else begin
            instr_d       = mem.mem_rdata;
            instr_pc_d    = req_addr_q;
            instr_valid_d = 1'b1;
            if (rdata_is_hlt) begin
              halted_d = 1'b1;
              state_d  = FETCH_HALTED;
            end else begin
              pc_stall = 1'b0;
              state_d  = FETCH_ISSUE;
            end
          end
        end else if (wd_expired) begin
          fetch_err_d = 1'b1;
          halted_d    = 1'b1;
          state_d     = FETCH_HALTED;
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end

      FETCH_HALTED: begin
        state_d = FETCH_HALTED;
      end

      default: begin
        state_d = FETCH_ISSUE;
      end
    endcase
  end

  // State and captured-instruction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH_ISSUE;
      req_addr_q    <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fetch_err_q   <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      fetch_err_q   <= fetch_err_d;
      drop_q        <= drop_d;
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit. The bench plays both the PC updater
//   (drives pc_in/flush) and the instruction memory (drives mem_rvalid and
//   mem_rdata cycle by cycle). Cycle 0 of every scenario is the first cycle
//   after reset release. Inputs change 1 time unit after the rising edge and
//   outputs are sampled 2 units later.
module tb_instr_fetch_unit;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] pc_in = '0;
  logic              flush = 1'b0;
  logic              pc_stall;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              halted;
  logic              fetch_err;

  int n_compared   = 0;
  int n_mismatched = 0;
  int valid_count  = 0;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  instr_fetch_unit #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_in       (pc_in),
    .flush       (flush),
    .pc_stall    (pc_stall),
    .mem         (mem_if),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .halted      (halted),
    .fetch_err   (fetch_err)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Counts instr_valid pulses so a scenario can check how many it produced.
  always @(negedge clk) begin
    if (instr_valid === 1'b1) valid_count++;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: got still running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Holds reset for two edges with quiet inputs, then releases it; on return
  // the caller is at the start of cycle 0.
  task automatic do_reset(input logic [ADDR_W-1:0] start_pc);
    rst_n = 1'b0;
    pc_in = start_pc;
    flush = 1'b0;
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_rdata  = '0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  // Register outputs must sit at their reset values while rst_n is low.
  task automatic test_reset();
    rst_n = 1'b0;
    mem_if.mem_rvalid = 1'b0;
    next_cycle();
    settle();
    n_compared++;
    if (instr !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL reset_instr: got %h expected 0000", instr); end
    n_compared++;
    if (instr_pc !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL reset_instr_pc: got %h expected 0000", instr_pc); end
    n_compared++;
    if ({instr_valid, halted, fetch_err} !== 3'b000) begin n_mismatched++; $display("[TB] FAIL reset_flags: got %b expected 000", {instr_valid, halted, fetch_err}); end
  endtask

  // Latency 2, word 1234 at address 0.
  task automatic test_single_fetch();
    do_reset(16'h0000);
    settle();
    n_compared++;
    if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL single_req: got req=%b addr=%h expected req=1 addr=0000", mem_if.mem_req, mem_if.mem_addr); end
    n_compared++;
    if (pc_stall !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_stall_c0: got %b expected 1", pc_stall); end
    next_cycle();
    settle();
    n_compared++;
    if (mem_if.mem_req !== 1'b0 || pc_stall !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_c1: got req=%b stall=%b expected req=0 stall=1", mem_if.mem_req, pc_stall); end
    next_cycle();
    mem_if.mem_rvalid = 1'b1;
    mem_if.mem_rdata  = 16'h1234;
    settle();
    n_compared++;
    if (pc_stall !== 1'b0 || instr_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL single_c2: got stall=%b valid=%b expected stall=0 valid=0", pc_stall, instr_valid); end
    next_cycle();
    mem_if.mem_rvalid = 1'b0;
    pc_in = 16'h0002;
    settle();
    n_compared++;
    if (instr_valid !== 1'b1 || instr !== 16'h1234 || instr_pc !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL single_c3: got valid=%b instr=%h pc=%h expected valid=1 instr=1234 pc=0000", instr_valid, instr, instr_pc); end
    n_compared++;
    if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 16'h0002 || pc_stall !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_next_req: got req=%b addr=%h stall=%b expected req=1 addr=0002 stall=1", mem_if.mem_req, mem_if.mem_addr, pc_stall); end
  endtask

  // Latency 1, PC 0 -> 2 -> 4: a request every second cycle.
  task automatic test_sequential();
    int start_count;
    logic [ADDR_W-1:0] pc;
    do_reset(16'h0000);
    start_count = valid_count;
    for (int i = 0; i < 3; i++) begin
      pc = ADDR_W'(2 * i);
      pc_in = pc;
      mem_if.mem_rvalid = 1'b0;
      settle();
      n_compared++;
      if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== pc) begin n_mismatched++; $display("[TB] FAIL seq_req_%0d: got req=%b addr=%h expected req=1 addr=%h", i, mem_if.mem_req, mem_if.mem_addr, pc); end
      if (i > 0) begin
        n_compared++;
        if (instr_valid !== 1'b1 || instr_pc !== pc - 16'd2) begin n_mismatched++; $display("[TB] FAIL seq_valid_%0d: got valid=%b pc=%h expected valid=1 pc=%h", i, instr_valid, instr_pc, pc - 16'd2); end
      end
      next_cycle();
      mem_if.mem_rvalid = 1'b1;
      mem_if.mem_rdata  = 16'h1000 + 16'(i);
      settle();
      n_compared++;
      if (mem_if.mem_req !== 1'b0 || pc_stall !== 1'b0) begin n_mismatched++; $display("[TB] FAIL seq_wait_%0d: got req=%b stall=%b expected req=0 stall=0", i, mem_if.mem_req, pc_stall); end
      next_cycle();
    end
    mem_if.mem_rvalid = 1'b0;
    pc_in = 16'h0006;
    settle();
    n_compared++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0004 || instr !== 16'h1002) begin n_mismatched++; $display("[TB] FAIL seq_last: got valid=%b pc=%h instr=%h expected valid=1 pc=0004 instr=1002", instr_valid, instr_pc, instr); end
    next_cycle();
    n_compared++;
    if (valid_count - start_count !== 3) begin n_mismatched++; $display("[TB] FAIL seq_pulses: got %0d expected 3", valid_count - start_count); end
  endtask

  // Flush while waiting on address 4, redirect to 20; then a flush that
  // coincides with the response for 22.
  task automatic test_flush();
    do_reset(16'h0004);
    settle();
    n_compared++;
    if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 16'h0004) begin n_mismatched++; $display("[TB] FAIL flush_req4: got req=%b addr=%h expected req=1 addr=0004", mem_if.mem_req, mem_if.mem_addr); end
    next_cycle();
    flush = 1'b1;
    settle();
    n_compared++;
    if (pc_stall !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_stall: got %b expected 0", pc_stall); end
    next_cycle();
    flush = 1'b0;
    pc_in = 16'h0014;
    mem_if.mem_rvalid = 1'b1;
    mem_if.mem_rdata  = 16'h4444;
    settle();
    n_compared++;
    if (pc_stall !== 1'b1 || mem_if.mem_req !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_stale_cycle: got stall=%b req=%b expected stall=1 req=0", pc_stall, mem_if.mem_req); end
    next_cycle();
    mem_if.mem_rvalid = 1'b0;
    settle();
    n_compared++;
    if (instr_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_dropped: got valid=%b expected 0", instr_valid); end
    n_compared++;
    if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 16'h0014) begin n_mismatched++; $display("[TB] FAIL flush_redirect_req: got req=%b addr=%h expected req=1 addr=0014", mem_if.mem_req, mem_if.mem_addr); end
    next_cycle();
    mem_if.mem_rvalid = 1'b1;
    mem_if.mem_rdata  = 16'h5555;
    settle();
    next_cycle();
    mem_if.mem_rvalid = 1'b0;
    pc_in = 16'h0016;
    settle();
    n_compared++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0014 || instr !== 16'h5555) begin n_mismatched++; $display("[TB] FAIL flush_new_instr: got valid=%b pc=%h instr=%h expected valid=1 pc=0014 instr=5555", instr_valid, instr_pc, instr); end
    next_cycle();
    flush = 1'b1;
    mem_if.mem_rvalid = 1'b1;
    mem_if.mem_rdata  = 16'h6666;
    settle();
    n_compared++;
    if (pc_stall !== 1'b0) begin n_mismatched++; $display("[TB] FAIL flush_coincident_stall: got %b expected 0", pc_stall); end
    next_cycle();
    flush = 1'b0;
    mem_if.mem_rvalid = 1'b0;
    pc_in = 16'h0028;
    settle();
    n_compared++;
    if (instr_valid !== 1'b0 || instr !== 16'h5555) begin n_mismatched++; $display("[TB] FAIL flush_coincident_drop: got valid=%b instr=%h expected valid=0 instr=5555", instr_valid, instr); end
    n_compared++;
    if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 16'h0028) begin n_mismatched++; $display("[TB] FAIL flush_coincident_req: got req=%b addr=%h expected req=1 addr=0028", mem_if.mem_req, mem_if.mem_addr); end
  endtask

  // HLT word at address 6; afterwards nothing moves for 10 cycles even with
  // stray rvalid and flush.
  task automatic test_hlt();
    int req_seen;
    do_reset(16'h0006);
    next_cycle();
    mem_if.mem_rvalid = 1'b1;
    mem_if.mem_rdata  = 16'hF000;
    settle();
    n_compared++;
    if (pc_stall !== 1'b1) begin n_mismatched++; $display("[TB] FAIL hlt_stall_on_rvalid: got %b expected 1", pc_stall); end
    next_cycle();
    mem_if.mem_rvalid = 1'b0;
    pc_in = 16'h0008;
    settle();
    n_compared++;
    if (instr_valid !== 1'b1 || instr !== 16'hF000 || instr_pc !== 16'h0006) begin n_mismatched++; $display("[TB] FAIL hlt_pulse: got valid=%b instr=%h pc=%h expected valid=1 instr=f000 pc=0006", instr_valid, instr, instr_pc); end
    n_compared++;
    if (halted !== 1'b1 || fetch_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hlt_flags: got halted=%b err=%b expected halted=1 err=0", halted, fetch_err); end
    req_seen = 0;
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      mem_if.mem_rvalid = k[0];
      mem_if.mem_rdata  = 16'h2222;
      flush = (k == 3);
      settle();
      if (mem_if.mem_req === 1'b1) req_seen++;
      n_compared++;
      if (pc_stall !== 1'b1 || instr_valid !== 1'b0 || halted !== 1'b1) begin n_mismatched++; $display("[TB] FAIL hlt_hold_%0d: got stall=%b valid=%b halted=%b expected 1 0 1", k, pc_stall, instr_valid, halted); end
    end
    flush = 1'b0;
    mem_if.mem_rvalid = 1'b0;
    n_compared++;
    if (req_seen !== 0) begin n_mismatched++; $display("[TB] FAIL hlt_no_req: got %0d requests expected 0", req_seen); end
  endtask

  // TIMEOUT=8, no response: flags appear 8 cycles after the request; a late
  // response is ignored.
  task automatic test_timeout();
    do_reset(16'h0000);
    settle();
    n_compared++;
    if (mem_if.mem_req !== 1'b1) begin n_mismatched++; $display("[TB] FAIL to_req: got %b expected 1", mem_if.mem_req); end
    for (int c = 1; c < 8; c++) begin
      next_cycle();
      settle();
      n_compared++;
      if ({halted, fetch_err} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL to_early_c%0d: got halted/err=%b expected 00", c, {halted, fetch_err}); end
    end
    next_cycle();
    settle();
    n_compared++;
    if ({halted, fetch_err} !== 2'b11) begin n_mismatched++; $display("[TB] FAIL to_expired_c8: got halted/err=%b expected 11", {halted, fetch_err}); end
    mem_if.mem_rvalid = 1'b1;
    mem_if.mem_rdata  = 16'h1234;
    next_cycle();
    next_cycle();
    mem_if.mem_rvalid = 1'b0;
    settle();
    n_compared++;
    if (instr_valid !== 1'b0 || instr !== 16'h0000 || mem_if.mem_req !== 1'b0) begin n_mismatched++; $display("[TB] FAIL to_late_rvalid: got valid=%b instr=%h req=%b expected valid=0 instr=0000 req=0", instr_valid, instr, mem_if.mem_req); end
  endtask

  // Odd PC: no request, error flags the next cycle.
  task automatic test_misaligned();
    do_reset(16'h0003);
    settle();
    n_compared++;
    if (mem_if.mem_req !== 1'b0 || {halted, fetch_err} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL mis_c0: got req=%b halted/err=%b expected req=0 00", mem_if.mem_req, {halted, fetch_err}); end
    next_cycle();
    settle();
    n_compared++;
    if (mem_if.mem_req !== 1'b0 || {halted, fetch_err} !== 2'b11) begin n_mismatched++; $display("[TB] FAIL mis_c1: got req=%b halted/err=%b expected req=0 11", mem_if.mem_req, {halted, fetch_err}); end
  endtask

  // Reset asserted in the middle of a wait clears everything at once, and a
  // response arriving after release (outside WAIT) is ignored.
  task automatic test_reset_mid_wait();
    do_reset(16'h0008);
    next_cycle();
    mem_if.mem_rvalid = 1'b1;
    mem_if.mem_rdata  = 16'hABCD;
    next_cycle();
    mem_if.mem_rvalid = 1'b0;
    pc_in = 16'h000A;
    next_cycle();
    settle();
    n_compared++;
    if (instr !== 16'hABCD || instr_pc !== 16'h0008) begin n_mismatched++; $display("[TB] FAIL rmw_before: got instr=%h pc=%h expected abcd 0008", instr, instr_pc); end
    rst_n = 1'b0;
    #1;
    n_compared++;
    if (instr !== 16'h0000 || instr_pc !== 16'h0000 || {instr_valid, halted, fetch_err} !== 3'b000) begin n_mismatched++; $display("[TB] FAIL rmw_immediate: got instr=%h pc=%h flags=%b expected 0000 0000 000", instr, instr_pc, {instr_valid, halted, fetch_err}); end
    n_compared++;
    if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 16'h000A) begin n_mismatched++; $display("[TB] FAIL rmw_issue_state: got req=%b addr=%h expected req=1 addr=000a", mem_if.mem_req, mem_if.mem_addr); end
    next_cycle();
    rst_n = 1'b1;
    mem_if.mem_rvalid = 1'b1;
    mem_if.mem_rdata  = 16'h7777;
    next_cycle();
    mem_if.mem_rvalid = 1'b0;
    settle();
    n_compared++;
    if (instr_valid !== 1'b0 || mem_if.mem_req !== 1'b0 || instr !== 16'h0000) begin n_mismatched++; $display("[TB] FAIL rmw_stale_ignored: got valid=%b req=%b instr=%h expected 0 0 0000", instr_valid, mem_if.mem_req, instr); end
  endtask

  initial begin
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_rdata  = '0;
    test_reset();
    test_single_fetch();
    test_sequential();
    test_flush();
    test_hlt();
    test_timeout();
    test_misaligned();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
